// File: rtl/read_audio.sv
// read_audio: streams one captured frame out of the sample RAM,
// optionally in bit-reversed address order, with a valid/ready handshake.
module read_audio #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 10,
    parameter int BIT_REV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_do_read_audio,
    output logic              o_did_read_audio,
    output logic              o_busy,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_sample_out,
    output logic              o_sample_valid,
    input  logic              i_sample_ready,
    output logic              o_sample_last,
    output logic [ADDR_W-1:0] o_sample_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] w_next_idx;

    // Natural-order index to RAM address
    function automatic logic [ADDR_W-1:0] f_map(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if (BIT_REV != 0) begin
            for (int i = 0; i < ADDR_W; i++) begin
                r[i] = a[ADDR_W-1-i];
            end
        end
        return r;
    endfunction

    assign w_next_idx = r_index + ADDR_W'(1);

    // Frame sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_index          <= '0;
            o_did_read_audio <= 1'b0;
            o_busy           <= 1'b0;
            o_mem_rd_en      <= 1'b0;
            o_mem_addr       <= '0;
            o_sample_out     <= '0;
            o_sample_valid   <= 1'b0;
            o_sample_last    <= 1'b0;
            o_sample_index   <= '0;
        end else begin
            o_did_read_audio <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_do_read_audio) begin
                        r_index     <= '0;
                        o_mem_rd_en <= 1'b1;
                        o_mem_addr  <= f_map('0);
                        o_busy      <= 1'b1;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    o_mem_rd_en <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    o_sample_out   <= i_mem_data;
                    o_sample_index <= r_index;
                    o_sample_last  <= (r_index == {ADDR_W{1'b1}});
                    o_sample_valid <= 1'b1;
                    r_state        <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (i_sample_ready) begin
                        o_sample_valid <= 1'b0;
                        if (o_sample_last) begin
                            o_did_read_audio <= 1'b1;
                            r_state          <= S_DONE;
                        end else begin
                            r_index     <= w_next_idx;
                            o_mem_rd_en <= 1'b1;
                            o_mem_addr  <= f_map(w_next_idx);
                            r_state     <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/read_audio.md
# read_audio

Reads a captured audio frame out of the 1024-entry sample RAM and streams it, one sample at a time, to a downstream consumer such as the FFT or the pitch detector. It is the read-side counterpart of the capture path: the top module raises a request, this block walks the whole buffer and then pulses completion. It supports an optional bit-reversed address order, so the consumer sees samples in natural time order whichever order the writer used.

## Interface
- ADDR_W, 10, RAM address width; frame length N = 2^ADDR_W.
- DATA_W, 10, sample width.
- BIT_REV, 1, 1: mem_addr = bit-reverse(index); 0: mem_addr = index.

- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- do_read_audio  in  1  start request from top module (level).
- did_read_audio  out  1  one-cycle pulse when the frame has been fully transferred.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM read address.
- mem_data  in  DATA_W  RAM read data; valid the cycle after mem_rd_en (1-cycle synchronous latency).
- sample_out  out  DATA_W  streamed sample.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  consumer accepts the sample when valid & ready.
- sample_last  out  1  high with the sample whose index is N-1.
- sample_index  out  ADDR_W  natural-order index of sample_out.

## Operation
- FSM states: IDLE, READ, WAIT, PRESENT, DONE.
- IDLE: outputs idle. If do_read_audio=1, clear index to 0 and go to READ.
- READ: mem_rd_en=1, mem_addr=map(index). Next state WAIT.
- WAIT: mem_rd_en=0. At the end of this cycle, register sample_out<=mem_data, sample_index<=index, sample_last<=(index==N-1), sample_valid<=1. Next state PRESENT.
- PRESENT: hold sample_valid=1 and keep sample_out/index/last stable until sample_ready=1. On transfer, sample_valid<=0. If sample_last, go to DONE; otherwise index<=index+1 and go to READ.
- DONE: did_read_audio=1 for exactly one cycle, then go to IDLE.
- map(): bit-reversal of all ADDR_W bits when BIT_REV=1 (e.g. ADDR_W=10: index 1 -> addr 512, index 3 -> addr 768). Identity when BIT_REV=0.
- index is ADDR_W bits and never wraps; termination is decided by sample_last, not by overflow.
- do_read_audio is ignored outside IDLE. Deasserting it mid-frame does not abort the frame.
- If do_read_audio is still high when the FSM returns to IDLE, a new frame starts. The top module must drop the request on did_read_audio.
- The block never writes to the RAM.

## Timing
- Reset (rst_n=0 at a posedge): state IDLE, index 0. Every output is 0: did_read_audio, busy, mem_rd_en, mem_addr, sample_out, sample_valid, sample_last, sample_index.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No did_read_audio pulse and no further sample transfers.
- Start latency: do_read_audio sampled high in IDLE at edge t0 -> mem_rd_en=1 in cycle t0+1 -> sample_valid=1 in cycle t0+3.
- Throughput: 3 cycles per sample with sample_ready held high.
- A full frame with ready always high: the last transfer occurs in cycle t0+3N. did_read_audio is high in cycle t0+3N+1 and busy is low from t0+3N+2.
- Backpressure: each cycle of sample_ready=0 in PRESENT adds one cycle. sample_out must not change while valid & !ready.
- busy rises the cycle after the start is accepted and falls the cycle after DONE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with do_read_audio=1 -> all outputs 0, no mem_rd_en.
- Full frame, BIT_REV=1, ready=1: preload RAM with mem[a]=a. Sample k must equal bit-reverse(k) (k=1 -> 512, k=2 -> 256, k=1023 -> 1023). Expect 1024 transfers, sample_last only on k=1023, did_read_audio pulse in cycle t0+3073.
- BIT_REV=0 with the same RAM: sample k = k for all k; sample_index = k.
- Random backpressure (ready 50%): sample_out and sample_index stay stable while stalled, no samples lost or duplicated, exactly 1024 transfers, a single did pulse.
- Reset asserted after 100 transfers: outputs return to 0 the next cycle, no did pulse. A new request then restarts from index 0.
- do_read_audio held high through DONE: a second frame starts in the cycle after IDLE is re-entered. do_read_audio toggled mid-frame: no effect on the stream.
